// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port A has priority,
// port B is guaranteed progress by a saturating starvation counter.
module dmem_arbiter #(
    parameter int n            = 32,
    parameter int AW           = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [n-1:0]  a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [n-1:0]  a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [n-1:0]  b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [n-1:0]  b_rdata,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] addr,
    output logic [n-1:0]  data_in,
    input  logic [n-1:0]  data_out,
    output logic          b_starved
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]   cnt_q, cnt_d;
    logic         starved_q;
    logic         a_rvalid_q, b_rvalid_q;
    logic [n-1:0] a_rdata_q, b_rdata_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (b_req && (!a_req || starved_q)) b_gnt = 1'b1;
            else if (a_req)                     a_gnt = 1'b1;
        end
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        data_in  = '0;
        if (a_gnt) begin
            MemRead  = ~a_we;
            MemWrite = a_we;
            addr     = a_addr;
            data_in  = a_wdata;
        end else if (b_gnt) begin
            MemRead  = ~b_we;
            MemWrite = b_we;
            addr     = b_addr;
            data_in  = b_wdata;
        end
    end

    // A denied B request counts up and saturates; a grant or a dropped request clears it.
    always_comb begin
        cnt_d = '0;
        if (b_req && !b_gnt) cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            starved_q  <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            starved_q  <= (cnt_d == LIMIT);
            a_rvalid_q <= a_gnt & ~a_we;
            b_rvalid_q <= b_gnt & ~b_we;
            if (a_gnt && !a_we) a_rdata_q <= data_out;
            if (b_gnt && !b_we) b_rdata_q <= data_out;
        end
    end

    // A read response landing in a reset cycle is suppressed so it is never seen.
    assign a_rvalid  = a_rvalid_q & ~rst;
    assign b_rvalid  = b_rvalid_q & ~rst;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign b_starved = starved_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [5:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        MemRead, MemWrite, b_starved;
    logic [5:0]  addr;
    logic [31:0] data_in, data_out;

    logic [31:0] mem [64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign data_out = mem[addr];
    always @(posedge clk) if (MemWrite) mem[addr] <= data_in;

    dmem_arbiter #(.n(32), .AW(6), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
        .data_in(data_in), .data_out(data_out), .b_starved(b_starved)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1] = 32'd9;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2; b_wdata = '0;

        // Reset with both requests present
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_memread", MemRead, 0);
        check("rst_memwrite", MemWrite, 0);
        tick();
        tick();
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        #1;
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_starved", b_starved, 0);
        check("idle_addr", addr, 0);
        check("idle_data_in", data_in, 0);

        // Solo read of mem[1]
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
        #1;
        check("solo_a_gnt", a_gnt, 1);
        check("solo_b_gnt", b_gnt, 0);
        check("solo_memread", MemRead, 1);
        check("solo_addr", addr, 1);
        tick();
        a_req = 1'b0;
        check("solo_rvalid", a_rvalid, 1);
        check("solo_rdata", a_rdata, 9);
        check("solo_b_rvalid", b_rvalid, 0);
        tick();
        check("solo_rvalid_drop", a_rvalid, 0);
        check("solo_rdata_hold", a_rdata, 9);

        // B writes, A reads the same address next cycle
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'd5; b_wdata = 32'hDEADBEEF;
        #1;
        check("wr_b_gnt", b_gnt, 1);
        check("wr_memwrite", MemWrite, 1);
        check("wr_memread", MemRead, 0);
        check("wr_data_in", data_in, 32'hDEADBEEF);
        tick();
        b_req = 1'b0; b_we = 1'b0;
        a_req = 1'b1; a_addr = 6'd5;
        #1;
        check("rd_a_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0;
        check("wr_no_b_rvalid", b_rvalid, 0);
        check("rd_rvalid", a_rvalid, 1);
        check("rd_rdata", a_rdata, 32'hDEADBEEF);

        // Priority: both request, A wins, B gets the next idle cycle
        a_req = 1'b1; a_addr = 6'd1;
        b_req = 1'b1; b_addr = 6'd5;
        #1;
        check("prio_a_gnt", a_gnt, 1);
        check("prio_b_gnt", b_gnt, 0);
        tick();
        a_req = 1'b0;
        #1;
        check("prio_b_next", b_gnt, 1);
        check("prio_a_rdata", a_rdata, 9);
        tick();
        b_req = 1'b0;
        check("prio_b_rvalid", b_rvalid, 1);
        check("prio_b_rdata", b_rdata, 32'hDEADBEEF);
        check("prio_a_rvalid_drop", a_rvalid, 0);

        // Starvation: continuous traffic on both ports, B wins every 5th cycle
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_b_gnt_%0d", i), b_gnt, (i % 5 == 4));
            check($sformatf("starve_a_gnt_%0d", i), a_gnt, (i % 5 != 4));
            check($sformatf("starve_flag_%0d", i), b_starved, (i % 5 == 4));
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        check("starve_b_rvalid", b_rvalid, 1);
        check("starve_flag_clear", b_starved, 0);

        // Cancel: B drops after 2 denials, so a new request needs a full 4 again
        a_req = 1'b1; b_req = 1'b1;
        tick();
        tick();
        b_req = 1'b0;
        tick();
        b_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("cancel_b_gnt_%0d", i), b_gnt, (i == 4));
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Reset right after an A read grant suppresses its response
        a_req = 1'b1; a_addr = 6'd1;
        #1;
        check("rstmid_a_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0; rst = 1'b1;
        #1;
        check("rstmid_rvalid_in_rst", a_rvalid, 0);
        tick();
        rst = 1'b0;
        check("rstmid_rvalid_after", a_rvalid, 0);
        check("rstmid_starved", b_starved, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - Port A: pipeline MEM stage, priority port.
  - Port B: loader/debug port, used for program/data preload and memory inspection.
- Grants at most one access per cycle and drives the memory's MemRead/MemWrite/addr/data_in.
- Returns read data registered one cycle later.
- A starvation counter guarantees port B forward progress under continuous port A traffic.

Parameters:
- n, 32, data width of memory words and both ports.
- AW, 6, memory word-address width.
- STARVE_LIMIT, 4, consecutive cycles port B may be denied before it is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- a_req  input  1  port A access request, held until granted.
- a_we  input  1  port A write (1) / read (0).
- a_addr  input  AW  port A word address.
- a_wdata  input  n  port A write data.
- a_gnt  output  1  port A granted this cycle (combinational).
- a_rvalid  output  1  port A read data valid (registered).
- a_rdata  output  n  port A read data (registered).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same widths and meanings for port B.
- MemRead  output  1  to memory read enable.
- MemWrite  output  1  to memory write enable.
- addr  output  AW  to memory address.
- data_in  output  n  to memory write data.
- data_out  input  n  from memory, asynchronous read data.
- b_starved  output  1  starvation counter has reached STARVE_LIMIT (registered, debug).

Behaviour:
- Reset (rst=1 at rising edge): a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0, starvation counter=0, b_starved=0.
  - During any cycle with rst=1: a_gnt=b_gnt=0, MemRead=MemWrite=0, addr=0, data_in=0, even if requests are present.
- Arbitration is combinational, evaluated each cycle:
  - Only a_req: A wins.
  - Only b_req: B wins.
  - Both requesting, b_starved=0: A wins.
  - Both requesting, b_starved=1: B wins.
  - Neither requesting: no grant.
- Exactly one of a_gnt/b_gnt is high when any request is present; never both.
- Memory drive for the winner W:
  - MemRead = ~W_we.
  - MemWrite = W_we.
  - addr = W_addr.
  - data_in = W_wdata.
  - With no grant: MemRead=MemWrite=0, addr=0, data_in=0.
- Write completes at the rising edge ending the grant cycle; no response pulse.
- Read latency is 1 cycle:
  - data_out is captured at the rising edge ending the grant cycle into W_rdata.
  - W_rvalid is high for exactly the following cycle.
  - x_rvalid is cleared in any cycle after which port x had no granted read.
  - x_rdata holds its last value when x_rvalid=0.
- Starvation counter (4 bits):
  - b_req=1 and b_gnt=0: increments, saturating at STARVE_LIMIT.
  - b_gnt=1 or b_req=0: clears to 0.
  - b_starved = (counter == STARVE_LIMIT).
- Requesters must hold req/we/addr/wdata stable until the cycle their gnt is high.
  - Dropping req before grant is legal and cancels the access.
  - Dropping b_req also clears the counter next edge.
- Back-to-back:
  - A granted port may re-request in the very next cycle.
  - Full throughput is one access per cycle total.
  - A read and the following write to the same address by different ports occur in grant order; a read after a write returns the written value.
- Reset mid-operation: a read granted in the cycle before rst produces no rvalid; the counter returns to 0.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with a_req=b_req=1.
  - Required: no gnt; MemRead=MemWrite=0.
  - After release: all rvalid=0, rdata=0, b_starved=0.
- Solo read:
  - Stimulus: preload mem[1]=9; A read addr 1.
  - Required: a_gnt in cycle 0; a_rvalid=1 and a_rdata=9 in cycle 1 only; b_rvalid stays 0.
- Write then read across ports:
  - Stimulus: B writes 0xDEADBEEF to addr 5 (granted); next cycle A reads addr 5.
  - Required: a_rdata=0xDEADBEEF.
- Priority:
  - Stimulus: both request in the same cycle with b_starved=0.
  - Required: a_gnt=1, b_gnt=0; B granted the first cycle A is idle.
- Starvation:
  - Stimulus: A requests continuously, B requests continuously, STARVE_LIMIT=4.
  - Required: B denied 4 cycles; b_starved=1 in cycle 4; b_gnt=1 in cycle 4; counter returns to 0; pattern repeats every 5 cycles.
- Cancel and reset mid-read:
  - Stimulus 1: B drops b_req after 2 denied cycles.
  - Required: counter clears.
  - Stimulus 2: rst asserted the cycle after an A read grant.
  - Required: a_rvalid stays 0.
